// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encoding and default timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/arb_timeout_counter.sv
// Cycle counter for an outstanding memory access; flags the last cycle before abort.
module arb_timeout_counter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_r;

  // Count BUSY cycles; clear whenever no access is outstanding.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en_i) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign tc_o = (cnt_r == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data-memory accesses onto one single-port memory
// with an ack handshake; returns a registered one-cycle ready pulse per access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_kill_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_rd_i,
  input  logic              dm_wr_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ready_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  state_t            state_r, state_nx_s;
  logic              grant_dm_r, kill_r, timeout_r;
  logic [DATA_W-1:0] data_r;
  logic              busy_s, start_dm_s, start_if_s, kill_set_s, if_drop_s, cnt_tc_s;

  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (!busy_s),
    .en_i  (busy_s),
    .tc_o  (cnt_tc_s)
  );

  // Next-state and grant decisions; DM beats IF because it belongs to the older instruction.
  always_comb begin
    state_nx_s = state_r;
    start_dm_s = 1'b0;
    start_if_s = 1'b0;
    busy_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (dm_rd_i || dm_wr_i) begin
          start_dm_s = 1'b1;
          state_nx_s = BUSY_DM;
        end else if (if_req_i) begin
          start_if_s = 1'b1;
          state_nx_s = BUSY_IF;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY_IF, BUSY_DM: begin
        busy_s = 1'b1;
        if (mem_ack_i || cnt_tc_s) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = state_r;
        end
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // A kill arriving in the RESP cycle itself must still suppress that response.
  assign kill_set_s = if_kill_i && ((state_r == BUSY_IF) || ((state_r == RESP) && !grant_dm_r));
  assign if_drop_s  = kill_r || kill_set_s;

  // State register plus every registered memory-side and requester-side output.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r     <= IDLE;
      grant_dm_r  <= 1'b0;
      kill_r      <= 1'b0;
      timeout_r   <= 1'b0;
      data_r      <= {DATA_W{1'b0}};
      if_ready_o  <= 1'b0;
      if_rdata_o  <= {DATA_W{1'b0}};
      dm_ready_o  <= 1'b0;
      dm_rdata_o  <= {DATA_W{1'b0}};
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= {ADDR_W{1'b0}};
      mem_wdata_o <= {DATA_W{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      if_ready_o <= 1'b0;
      dm_ready_o <= 1'b0;
      err_o      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_dm_s) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= dm_wr_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
            grant_dm_r  <= 1'b1;
            timeout_r   <= 1'b0;
          end else if (start_if_s) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= {DATA_W{1'b0}};
            grant_dm_r  <= 1'b0;
            timeout_r   <= 1'b0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          kill_r <= kill_r | kill_set_s;
          if (mem_ack_i) begin
            data_r    <= mem_we_o ? {DATA_W{1'b0}} : mem_rdata_i;
            timeout_r <= 1'b0;
            mem_req_o <= 1'b0;
          end else if (cnt_tc_s) begin
            data_r    <= {DATA_W{1'b0}};
            timeout_r <= 1'b1;
            mem_req_o <= 1'b0;
          end
        end
        RESP: begin
          kill_r <= 1'b0;
          if (grant_dm_r) begin
            dm_ready_o <= 1'b1;
            dm_rdata_o <= data_r;
            err_o      <= timeout_r;
          end else if (!if_drop_s) begin
            if_ready_o <= 1'b1;
            if_rdata_o <= data_r;
            err_o      <= timeout_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 ns after each rising edge,
// outputs are sampled at the same point, so each step() covers exactly one clock.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, if_kill_i, if_ready_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        dm_rd_i, dm_wr_i, dm_ready_o, err_o;
  logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_kill_i   (if_kill_i),
    .if_ready_o  (if_ready_o),
    .if_rdata_o  (if_rdata_o),
    .dm_rd_i     (dm_rd_i),
    .dm_wr_i     (dm_wr_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_ready_o  (dm_ready_o),
    .dm_rdata_o  (dm_rdata_o),
    .err_o       (err_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b0; if_req_i = 1'b0; if_kill_i = 1'b0; if_addr_i = 32'h0;
    dm_rd_i = 1'b0; dm_wr_i = 1'b0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    step(); step();
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_ready", {30'd0, if_ready_o, dm_ready_o}, 32'd0);
    rst_i = 1'b1;

    // 1: reset in the middle of a DM write
    dm_wr_i = 1'b1; dm_addr_i = 32'h40; dm_wdata_i = 32'h55;
    step();
    chk("t1_req", {31'd0, mem_req_o}, 32'd1);
    chk("t1_we", {31'd0, mem_we_o}, 32'd1);
    dm_wr_i = 1'b0;
    step();
    rst_i = 1'b0;
    step();
    chk("t1_req_rst", {31'd0, mem_req_o}, 32'd0);
    chk("t1_we_rst", {31'd0, mem_we_o}, 32'd0);
    chk("t1_addr_rst", mem_addr_o, 32'h0);
    chk("t1_wdata_rst", mem_wdata_o, 32'h0);
    chk("t1_state_rst", {30'd0, dut.state_r}, 32'd0);
    rst_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h77;
    for (int i = 0; i < 4; i++) begin
      step();
      mem_ack_i = 1'b0;
      chk("t1_no_ready", {29'd0, if_ready_o, dm_ready_o, err_o}, 32'd0);
      chk("t1_no_req", {31'd0, mem_req_o}, 32'd0);
    end

    // 2: IF read, ack in the second BUSY cycle, ready 4 cycles after request
    if_req_i = 1'b1; if_addr_i = 32'h100;
    step();
    chk("t2_req", {31'd0, mem_req_o}, 32'd1);
    chk("t2_addr", mem_addr_o, 32'h100);
    chk("t2_we1", {31'd0, mem_we_o}, 32'd0);
    step();
    chk("t2_req_hold", {31'd0, mem_req_o}, 32'd1);
    chk("t2_we2", {31'd0, mem_we_o}, 32'd0);
    chk("t2_ready_early", {31'd0, if_ready_o}, 32'd0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h8C020004;
    step();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    chk("t2_req_drop", {31'd0, mem_req_o}, 32'd0);
    chk("t2_ready_resp", {31'd0, if_ready_o}, 32'd0);
    step();
    chk("t2_ready", {31'd0, if_ready_o}, 32'd1);
    chk("t2_rdata", if_rdata_o, 32'h8C020004);
    chk("t2_err", {31'd0, err_o}, 32'd0);
    if_req_i = 1'b0;
    step();
    chk("t2_ready_once", {31'd0, if_ready_o}, 32'd0);

    // 3: simultaneous IF and DM (write wins over read), DM first
    if_req_i = 1'b1; if_addr_i = 32'h200;
    dm_wr_i = 1'b1; dm_rd_i = 1'b1; dm_addr_i = 32'h10; dm_wdata_i = 32'hDEADBEEF;
    step();
    chk("t3_dm_addr", mem_addr_o, 32'h10);
    chk("t3_dm_we", {31'd0, mem_we_o}, 32'd1);
    chk("t3_dm_wdata", mem_wdata_o, 32'hDEADBEEF);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111;
    step();
    mem_ack_i = 1'b0;
    step();
    chk("t3_dm_ready", {30'd0, dm_ready_o, if_ready_o}, 32'd2);
    chk("t3_dm_rdata", dm_rdata_o, 32'h0);
    dm_wr_i = 1'b0; dm_rd_i = 1'b0;
    step();
    chk("t3_if_addr", mem_addr_o, 32'h200);
    chk("t3_if_we", {31'd0, mem_we_o}, 32'd0);
    chk("t3_if_wdata", mem_wdata_o, 32'h0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    step();
    mem_ack_i = 1'b0;
    step();
    chk("t3_if_ready", {30'd0, dm_ready_o, if_ready_o}, 32'd1);
    chk("t3_if_rdata", if_rdata_o, 32'hCAFEF00D);
    if_req_i = 1'b0;
    step();

    // 6: back-to-back DM reads with the request held
    dm_rd_i = 1'b1; dm_addr_i = 32'h4;
    step();
    chk("t6_addr0", mem_addr_o, 32'h4);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hA4;
    step();
    mem_ack_i = 1'b0;
    chk("t6_resp0", {31'd0, dm_ready_o}, 32'd0);
    step();
    chk("t6_ready0", {31'd0, dm_ready_o}, 32'd1);
    chk("t6_rdata0", dm_rdata_o, 32'hA4);
    dm_addr_i = 32'h8;
    step();
    chk("t6_gap", {31'd0, dm_ready_o}, 32'd0);
    chk("t6_addr1", mem_addr_o, 32'h8);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hA8;
    step();
    mem_ack_i = 1'b0;
    chk("t6_resp1", {31'd0, dm_ready_o}, 32'd0);
    step();
    chk("t6_ready1", {31'd0, dm_ready_o}, 32'd1);
    chk("t6_rdata1", dm_rdata_o, 32'hA8);
    dm_rd_i = 1'b0;
    step();
    chk("t6_idle", {30'd0, dm_ready_o, mem_req_o}, 32'd0);

    // 4: DM read with no ack times out after 16 BUSY cycles
    dm_rd_i = 1'b1; dm_addr_i = 32'h20; mem_rdata_i = 32'hFFFFFFFF;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("t4_busy", {30'd0, mem_req_o, dm_ready_o}, 32'd2);
    end
    step();
    chk("t4_resp", {30'd0, mem_req_o, dm_ready_o}, 32'd0);
    step();
    chk("t4_ready_err", {30'd0, dm_ready_o, err_o}, 32'd3);
    chk("t4_rdata", dm_rdata_o, 32'h0);
    dm_rd_i = 1'b0;
    step();
    chk("t4_err_once", {30'd0, dm_ready_o, err_o}, 32'd0);

    // 5: IF killed while in flight; response suppressed, rdata held
    if_req_i = 1'b1; if_addr_i = 32'h300;
    step();
    chk("t5_req", {31'd0, mem_req_o}, 32'd1);
    if_kill_i = 1'b1; if_req_i = 1'b0;
    step();
    if_kill_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
    step();
    mem_ack_i = 1'b0;
    chk("t5_resp_state", {30'd0, dut.state_r}, 32'd3);
    step();
    chk("t5_no_ready", {30'd0, if_ready_o, err_o}, 32'd0);
    chk("t5_rdata_held", if_rdata_o, 32'hCAFEF00D);
    chk("t5_idle", {30'd0, dut.state_r}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
